// File: rtl/pll_reset_ctrl.sv
// Reset/lock sequencer for the system PLL: holds PLL reset, waits for lock with timeout,
// qualifies lock stability, then releases ready. Retries on failure and latches a fault.
module pll_reset_ctrl #(
  parameter int RST_HOLD_CYCLES = 24,
  parameter int LOCK_TIMEOUT    = 24000,
  parameter int LOCK_STABLE     = 240,
  parameter int MAX_RETRIES     = 3,
  parameter int CNT_W           = 16,
  parameter int RETRY_W         = 4
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               pll_locked,
  input  logic               soft_rst_req,
  output logic               pll_rst,
  output logic               ready,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  state_t             st, st_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [RETRY_W-1:0] retry_n;
  logic               sync1, lock_s;
  logic               fail;

  // pll_locked is asynchronous to refclk
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= pll_locked;
      lock_s <= sync1;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= HOLD;
      cnt       <= '0;
      retry_cnt <= '0;
      pll_rst   <= 1'b1;
      ready     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      st        <= st_n;
      cnt       <= cnt_n;
      retry_cnt <= retry_n;
      pll_rst   <= (st_n == HOLD) || (st_n == FAULT);
      ready     <= (st_n == RUN);
      fault     <= (st_n == FAULT);
    end
  end

  always_comb begin
    st_n    = st;
    retry_n = retry_cnt;
    fail    = 1'b0;
    if (soft_rst_req) begin
      st_n    = HOLD;
      retry_n = '0;
    end else begin
      case (st)
        HOLD:
          if (cnt == CNT_W'(RST_HOLD_CYCLES - 1)) st_n = WAIT_LOCK;
        WAIT_LOCK:
          if (lock_s)                                 st_n = STABILIZE;
          else if (cnt == CNT_W'(LOCK_TIMEOUT - 1))   fail = 1'b1;
        STABILIZE:
          if (!lock_s) fail = 1'b1;
          else if (cnt == CNT_W'(LOCK_STABLE - 1)) begin
            st_n    = RUN;
            retry_n = '0;
          end
        RUN:
          if (!lock_s) fail = 1'b1;
        FAULT:   st_n = FAULT;
        default: st_n = HOLD;
      endcase
      // retry_cnt never exceeds MAX_RETRIES: the attempt after the last retry faults instead
      if (fail) begin
        if (retry_cnt == RETRY_W'(MAX_RETRIES)) begin
          st_n = FAULT;
        end else begin
          st_n    = HOLD;
          retry_n = retry_cnt + RETRY_W'(1);
        end
      end
    end
    cnt_n = (soft_rst_req || (st_n != st)) ? '0 : cnt + CNT_W'(1);
  end

  assign state = st;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed bench for pll_reset_ctrl with short phase parameters; edges counted from reset release.
module tb_pll_reset_ctrl;

  localparam int RETRY_W = 4;

  logic               refclk = 1'b0;
  logic               rst_n  = 1'b0;
  logic               pll_locked = 1'b0;
  logic               soft_rst_req = 1'b0;
  logic               pll_rst, ready, fault;
  logic [RETRY_W-1:0] retry_cnt;
  logic [2:0]         state;

  int checks = 0;
  int failures = 0;

  pll_reset_ctrl #(
    .RST_HOLD_CYCLES(4),
    .LOCK_TIMEOUT(16),
    .LOCK_STABLE(8),
    .MAX_RETRIES(2),
    .CNT_W(16),
    .RETRY_W(RETRY_W)
  ) dut (
    .refclk(refclk),
    .rst_n(rst_n),
    .pll_locked(pll_locked),
    .soft_rst_req(soft_rst_req),
    .pll_rst(pll_rst),
    .ready(ready),
    .fault(fault),
    .retry_cnt(retry_cnt),
    .state(state)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  // Leaves rst_n released on a falling edge so the next rising edge is edge 1
  task automatic do_reset(input logic lock);
    rst_n = 1'b0;
    soft_rst_req = 1'b0;
    pll_locked = lock;
    repeat (2) @(negedge refclk);
    rst_n = 1'b1;
  endtask

  initial begin
    // reset values and clean start
    do_reset(1'b1);
    rst_n = 1'b0;
    #2;
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_ready", ready, 0);
    chk("rst_fault", fault, 0);
    chk("rst_retry", retry_cnt, 0);
    chk("rst_state", state, 0);
    @(negedge refclk);
    rst_n = 1'b1;
    tick(4 - 1);
    chk("clean_e3_pll_rst", pll_rst, 1);
    chk("clean_e3_state", state, 0);
    tick(1);
    chk("clean_e4_pll_rst", pll_rst, 0);
    chk("clean_e4_state", state, 1);
    tick(1);
    chk("clean_e5_state", state, 2);
    tick(7);
    chk("clean_e12_ready", ready, 0);
    tick(1);
    chk("clean_e13_ready", ready, 1);
    chk("clean_e13_state", state, 3);
    chk("clean_retry", retry_cnt, 0);
    chk("clean_fault", fault, 0);

    // loss of lock in RUN (lock drops after edge 13)
    pll_locked = 1'b0;
    tick(2);
    chk("loss_e15_ready", ready, 1);
    tick(1);
    chk("loss_e16_ready", ready, 0);
    chk("loss_e16_pll_rst", pll_rst, 1);
    chk("loss_e16_retry", retry_cnt, 1);
    chk("loss_e16_state", state, 0);
    pll_locked = 1'b1;
    tick(12);
    chk("loss_relock_e28_ready", ready, 0);
    tick(1);
    chk("loss_relock_e29_ready", ready, 1);
    chk("loss_relock_retry", retry_cnt, 0);

    // lock chatter: lock_s low while STABILIZE counter=5 (edge 11)
    do_reset(1'b1);
    tick(8);
    pll_locked = 1'b0;
    tick(2);
    chk("chat_e10_state", state, 2);
    tick(1);
    chk("chat_e11_state", state, 0);
    chk("chat_e11_retry", retry_cnt, 1);
    pll_locked = 1'b1;
    tick(12);
    chk("chat_e23_state", state, 2);
    chk("chat_e23_ready", ready, 0);
    tick(1);
    chk("chat_e24_state", state, 3);
    chk("chat_e24_retry", retry_cnt, 0);

    // timeouts to fault
    do_reset(1'b0);
    tick(19);
    chk("to_e19_state", state, 1);
    chk("to_e19_retry", retry_cnt, 0);
    tick(1);
    chk("to_e20_state", state, 0);
    chk("to_e20_retry", retry_cnt, 1);
    tick(20);
    chk("to_e40_retry", retry_cnt, 2);
    tick(19);
    chk("to_e59_state", state, 1);
    chk("to_e59_fault", fault, 0);
    tick(1);
    chk("to_e60_state", state, 4);
    chk("to_e60_fault", fault, 1);
    chk("to_e60_pll_rst", pll_rst, 1);
    chk("to_e60_ready", ready, 0);
    chk("to_e60_retry", retry_cnt, 2);
    tick(30);
    chk("to_hold_fault", fault, 1);
    chk("to_hold_pll_rst", pll_rst, 1);
    chk("to_hold_state", state, 4);

    // fault recovery via soft request
    pll_locked = 1'b1;
    tick(3);
    chk("rec_pre_state", state, 4);
    soft_rst_req = 1'b1;
    tick(1);
    soft_rst_req = 1'b0;
    chk("rec_state", state, 0);
    chk("rec_fault", fault, 0);
    chk("rec_retry", retry_cnt, 0);
    chk("rec_pll_rst", pll_rst, 1);
    tick(12);
    chk("rec_p12_ready", ready, 0);
    tick(1);
    chk("rec_p13_ready", ready, 1);

    // soft request on the timeout cycle (edge 20)
    do_reset(1'b0);
    tick(19);
    soft_rst_req = 1'b1;
    tick(1);
    soft_rst_req = 1'b0;
    chk("pri_state", state, 0);
    chk("pri_retry", retry_cnt, 0);
    chk("pri_fault", fault, 0);
    tick(19);
    chk("pri_p19_retry", retry_cnt, 0);
    tick(1);
    chk("pri_p20_retry", retry_cnt, 1);

    // async reset mid-STABILIZE
    do_reset(1'b1);
    tick(7);
    chk("arst_pre_state", state, 2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_pll_rst", pll_rst, 1);
    chk("arst_ready", ready, 0);
    chk("arst_fault", fault, 0);
    chk("arst_retry", retry_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pll_reset_ctrl.md
# pll_reset_ctrl

Reset and lock sequencer for the 96 MHz system PLL. Runs on the 24 MHz reference clock. Drives the PLL reset for a fixed hold time, waits with a timeout for lock, then requires lock to stay stable before releasing `ready` to the FT232H FIFO logic. It retries on timeout or loss of lock, latches a fault after a bounded number of retries, and accepts a software re-lock request.

## Interface
Parameters:
- `RST_HOLD_CYCLES`, 24: refclk cycles spent in HOLD with `pll_rst`=1 (1 µs); ≥1
- `LOCK_TIMEOUT`, 24000: max refclk cycles in WAIT_LOCK (1 ms); ≥1
- `LOCK_STABLE`, 240: consecutive synced-lock cycles required in STABILIZE (10 µs); ≥1
- `MAX_RETRIES`, 3: failed attempts tolerated before FAULT; must be < 2^RETRY_W
- `CNT_W`, 16: phase counter width; must hold max(parameters)−1
- `RETRY_W`, 4: retry counter width

Ports:
- `refclk`  in  1  24 MHz reference clock; the only clock
- `rst_n`  in  1  asynchronous, active-low reset; deassertion synchronous to `refclk` (upstream synchronizer)
- `pll_locked`  in  1  PLL `locked`, asynchronous; 2-flop synchronized internally to `lock_s`
- `soft_rst_req`  in  1  single-cycle request to restart the sequence
- `pll_rst`  out  1  to PLL `rst`, active-high
- `ready`  out  1  PLL output valid; release for downstream reset
- `fault`  out  1  retries exhausted
- `retry_cnt`  out  RETRY_W  failed attempts since last RUN or soft request
- `state`  out  3  debug: HOLD=0, WAIT_LOCK=1, STABILIZE=2, RUN=3, FAULT=4

## Operation
- Reset values: state=HOLD, counter=0, retry_cnt=0, sync flops=0, `pll_rst`=1, `ready`=0, `fault`=0.
- All outputs are flops updated on the same edge as the state:
  - `pll_rst`=1 iff state ∈ {HOLD, FAULT}
  - `ready`=1 iff state=RUN
  - `fault`=1 iff state=FAULT
- The counter clears on every state change and increments each cycle otherwise.
- HOLD: on the edge where counter = RST_HOLD_CYCLES−1, go to WAIT_LOCK.
- WAIT_LOCK:
  - `lock_s`=1 → STABILIZE.
  - Else, when counter = LOCK_TIMEOUT−1 → FAIL.
- STABILIZE:
  - `lock_s`=0 → FAIL.
  - Else, when counter = LOCK_STABLE−1 → RUN, and retry_cnt clears to 0.
- RUN: `lock_s`=0 → FAIL.
- FAULT: held until `soft_rst_req` or `rst_n`.
- FAIL (transition action, not a state):
  - If retry_cnt = MAX_RETRIES → FAULT.
  - Else retry_cnt+1 and go to HOLD.
- `soft_rst_req`=1 in any state has highest priority. It forces HOLD, clears the counter and retry_cnt, and clears `fault`. It does not count as a failure.
- Simultaneous events:
  - `soft_rst_req` beats lock loss or timeout.
  - In WAIT_LOCK, lock arriving on the timeout cycle wins (→ STABILIZE).
  - In STABILIZE, lock loss on the final count cycle wins (→ FAIL).
- retry_cnt saturates by construction: it is never incremented past MAX_RETRIES.

## Timing
- Edge numbering: edge 1 is the first `refclk` rising edge with `rst_n`=1.
- Lock input latency: 2 cycles from `pll_locked` to `lock_s`.
- HOLD lasts exactly RST_HOLD_CYCLES cycles, so `pll_rst` falls after edge RST_HOLD_CYCLES.
- Minimum reset-release-to-`ready` time is RST_HOLD_CYCLES + 1 + LOCK_STABLE edges (lock already synchronized high).
- Loss of lock in RUN:
  - `pll_locked` falls; `ready` falls 3 edges later (2 sync + 1 state).
  - `pll_rst` rises on the same edge.
- `rst_n` assertion forces all reset values immediately, independent of `refclk`, in any state.

## Test plan
Bench parameters: RST_HOLD_CYCLES=4, LOCK_TIMEOUT=16, LOCK_STABLE=8, MAX_RETRIES=2.
- **Clean start.** `pll_locked` tied 1, release `rst_n` → `pll_rst`=1 through edge 4, 0 after; `ready` rises after edge 13; retry_cnt=0; `fault`=0.
- **Timeout to fault.** `pll_locked` tied 0 →
  - WAIT_LOCK times out after 16 cycles.
  - retry_cnt steps 1 then 2, one increment per 20-cycle attempt.
  - The third timeout enters FAULT after edge 60: `fault`=1, `pll_rst`=1, `ready`=0.
  - `fault` and `pll_rst` stay high indefinitely.
- **Fault recovery.** From FAULT, pulse `soft_rst_req` with lock=1 → state=HOLD, `fault`=0, retry_cnt=0; `ready` rises 13 edges later.
- **Lock chatter in STABILIZE.** Lock drops at STABILIZE counter=5 → retry_cnt=1 and return to HOLD; lock stays high thereafter → RUN, retry_cnt clears to 0.
- **Loss of lock in RUN.** Drop `pll_locked` → `ready` falls and `pll_rst` rises 3 edges later, retry_cnt=1; restore lock → `ready` again 13 edges after re-entry to HOLD.
- **Priority and reset.**
  - `soft_rst_req` on the same cycle as timeout → HOLD with retry_cnt=0.
  - `rst_n` asserted mid-STABILIZE → all outputs at reset values before the next `refclk` edge.
